// File: rtl/mmio_pkg.sv
// mmio_pkg: shared definitions for the MMIO FIFO bridge.
//   - register offsets (addr_in[3:0])
//   - CTRL bit layout (as a packed struct and as bit indices)
//   - STATUS bit indices and count-field positions
package mmio_pkg;

   // Register offsets
   localparam logic [3:0] OFF_CTRL    = 4'h0;
   localparam logic [3:0] OFF_TX_DATA = 4'h4;
   localparam logic [3:0] OFF_RX_DATA = 4'h8;
   localparam logic [3:0] OFF_STATUS  = 4'hC;

   // CTRL bit indices
   localparam int unsigned CTRL_ENABLE   = 0;
   localparam int unsigned CTRL_TX_FLUSH = 1;
   localparam int unsigned CTRL_RX_FLUSH = 2;
   localparam int unsigned CTRL_IRQ_EN   = 3;

   // Packed so that a 4-bit CTRL write maps directly onto the register
   typedef struct packed {
      logic irq_en;
      logic rx_flush;
      logic tx_flush;
      logic enable;
   } ctrl_t;

   // STATUS bit indices
   localparam int unsigned STAT_TX_FULL  = 0;
   localparam int unsigned STAT_TX_EMPTY = 1;
   localparam int unsigned STAT_RX_FULL  = 2;
   localparam int unsigned STAT_RX_EMPTY = 3;
   localparam int unsigned STAT_TX_OVF   = 4;
   localparam int unsigned STAT_RX_UDF   = 5;
   localparam int unsigned STAT_RX_OVF   = 6;

   // STATUS count fields
   localparam int unsigned STAT_TX_CNT_LSB = 8;
   localparam int unsigned STAT_RX_CNT_LSB = 16;
   localparam int unsigned STAT_CNT_W      = 8;

endpackage

// File: rtl/mmio_sync_fifo.sv
// mmio_sync_fifo: single-clock FIFO with flush.
//   clk, rst          : clock, asynchronous active-low reset
//   i_push, i_data    : push request and data (dropped when full unless popping too)
//   i_pop             : pop request (ignored when empty)
//   i_flush           : empty the FIFO; overrides push and pop
//   o_head            : data at the read pointer
//   o_full, o_empty   : occupancy flags
//   o_count           : number of stored entries
module mmio_sync_fifo #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned DEPTH  = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   i_push,
   input  logic [DATA_W-1:0]      i_data,
   input  logic                   i_pop,
   input  logic                   i_flush,
   output logic [DATA_W-1:0]      o_head,
   output logic                   o_full,
   output logic                   o_empty,
   output logic [$clog2(DEPTH):0] o_count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [AW-1:0]     r_wptr;
   logic [AW-1:0]     r_rptr;
   logic [AW:0]       r_count;
   logic              w_push;
   logic              w_pop;

   assign o_full  = (r_count == FULL_CNT);
   assign o_empty = (r_count == '0);
   assign o_count = r_count;
   assign o_head  = r_mem[r_rptr];

   assign w_pop  = i_pop && !o_empty;
   // A pop in the same cycle frees the slot, so a push into a full FIFO is still taken
   assign w_push = i_push && (!o_full || w_pop);

   // Pointers wrap naturally since DEPTH is a power of two
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else if (i_flush) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + 1'b1;
         if (w_pop)  r_rptr <= r_rptr + 1'b1;
         if (w_push && !w_pop) begin
            r_count <= r_count + 1'b1;
         end else if (!w_push && w_pop) begin
            r_count <= r_count - 1'b1;
         end
      end
   end

   // Storage is not reset
   always_ff @(posedge clk) begin
      if (w_push && !i_flush) r_mem[r_wptr] <= i_data;
   end

endmodule

// File: rtl/mmio_fifo_bridge.sv
// mmio_fifo_bridge: MMIO register block bridging a TX and an RX FIFO to valid/ready streams.
//   clk, rst                       : clock, asynchronous active-low reset
//   addr_in, data_in, wr_in, rd_in : MMIO access (selected by addr_in[SEL_BIT])
//   data_out, rd_valid_out         : read data, valid one cycle after a selected read
//   tx_valid_out/tx_data_out/tx_ready_in : TX stream (drains the TX FIFO)
//   rx_valid_in/rx_data_in/rx_ready_out  : RX stream (fills the RX FIFO)
//   irq_out                        : registered level interrupt
module mmio_fifo_bridge
   import mmio_pkg::*;
#(
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned DEPTH   = 8,
   parameter int unsigned SEL_BIT = 15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [31:0]       addr_in,
   input  logic [DATA_W-1:0] data_in,
   input  logic              wr_in,
   input  logic              rd_in,
   output logic [DATA_W-1:0] data_out,
   output logic              rd_valid_out,
   output logic              tx_valid_out,
   output logic [DATA_W-1:0] tx_data_out,
   input  logic              tx_ready_in,
   input  logic              rx_valid_in,
   input  logic [DATA_W-1:0] rx_data_in,
   output logic              rx_ready_out,
   output logic              irq_out
);

   localparam int unsigned CW = $clog2(DEPTH) + 1;

   ctrl_t             r_ctrl;
   logic              r_tx_ovf;
   logic              r_rx_udf;
   logic              r_rx_ovf;
   logic [DATA_W-1:0] r_data_out;
   logic              r_rd_valid;
   logic              r_irq;

   logic              w_unused;
   logic [3:0]        w_off;
   logic              w_wr;
   logic              w_rd;
   logic              w_tx_push;
   logic              w_tx_pop;
   logic              w_rx_push;
   logic              w_rx_rd;
   logic              w_stat_wr;
   logic              w_tx_full;
   logic              w_tx_empty;
   logic              w_rx_full;
   logic              w_rx_empty;
   logic [CW-1:0]     w_tx_count;
   logic [CW-1:0]     w_rx_count;
   logic [DATA_W-1:0] w_rx_head;
   logic [31:0]       w_status;
   logic [DATA_W-1:0] w_rdata;
   logic              w_tx_ovf_set;
   logic              w_rx_udf_set;
   logic              w_rx_ovf_set;

   assign w_unused = ^addr_in;

   assign w_off = addr_in[3:0];
   assign w_wr  = wr_in && addr_in[SEL_BIT];
   assign w_rd  = rd_in && addr_in[SEL_BIT];

   assign w_tx_push = w_wr && (w_off == OFF_TX_DATA);
   assign w_rx_rd   = w_rd && (w_off == OFF_RX_DATA);
   assign w_stat_wr = w_wr && (w_off == OFF_STATUS);

   assign tx_valid_out = r_ctrl.enable && !w_tx_empty;
   assign w_tx_pop     = tx_valid_out && tx_ready_in;
   assign rx_ready_out = r_ctrl.enable && !w_rx_full;
   assign w_rx_push    = rx_valid_in && rx_ready_out;

   assign w_tx_ovf_set = w_tx_push && w_tx_full && !w_tx_pop;
   assign w_rx_udf_set = w_rx_rd && w_rx_empty;
   assign w_rx_ovf_set = rx_valid_in && r_ctrl.enable && w_rx_full;

   mmio_sync_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_tx_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_tx_push),
      .i_data  (data_in),
      .i_pop   (w_tx_pop),
      .i_flush (r_ctrl.tx_flush),
      .o_head  (tx_data_out),
      .o_full  (w_tx_full),
      .o_empty (w_tx_empty),
      .o_count (w_tx_count)
   );

   mmio_sync_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_rx_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_rx_push),
      .i_data  (rx_data_in),
      .i_pop   (w_rx_rd),
      .i_flush (r_ctrl.rx_flush),
      .o_head  (w_rx_head),
      .o_full  (w_rx_full),
      .o_empty (w_rx_empty),
      .o_count (w_rx_count)
   );

   always_comb begin
      w_status = '0;
      w_status[STAT_TX_FULL]  = w_tx_full;
      w_status[STAT_TX_EMPTY] = w_tx_empty;
      w_status[STAT_RX_FULL]  = w_rx_full;
      w_status[STAT_RX_EMPTY] = w_rx_empty;
      w_status[STAT_TX_OVF]   = r_tx_ovf;
      w_status[STAT_RX_UDF]   = r_rx_udf;
      w_status[STAT_RX_OVF]   = r_rx_ovf;
      w_status[STAT_TX_CNT_LSB +: CW] = w_tx_count;
      w_status[STAT_RX_CNT_LSB +: CW] = w_rx_count;
   end

   // Read mux sees pre-write state, so a same-cycle write never leaks into the read
   always_comb begin
      w_rdata = '0;
      case (w_off)
         OFF_CTRL:    w_rdata[3:0]  = r_ctrl;
         OFF_RX_DATA: if (!w_rx_empty) w_rdata = w_rx_head;
         OFF_STATUS:  w_rdata[31:0] = w_status;
         default:     w_rdata = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_ctrl     <= '0;
         r_tx_ovf   <= 1'b0;
         r_rx_udf   <= 1'b0;
         r_rx_ovf   <= 1'b0;
         r_data_out <= '0;
         r_rd_valid <= 1'b0;
         r_irq      <= 1'b0;
      end else begin
         if (w_wr && (w_off == OFF_CTRL)) begin
            r_ctrl <= ctrl_t'(data_in[3:0]);
         end else begin
            // Flush bits last exactly one cycle
            r_ctrl.tx_flush <= 1'b0;
            r_ctrl.rx_flush <= 1'b0;
         end

         // Write-1-to-clear; a same-cycle set wins
         r_tx_ovf <= w_tx_ovf_set | (r_tx_ovf & ~(w_stat_wr & data_in[STAT_TX_OVF]));
         r_rx_udf <= w_rx_udf_set | (r_rx_udf & ~(w_stat_wr & data_in[STAT_RX_UDF]));
         r_rx_ovf <= w_rx_ovf_set | (r_rx_ovf & ~(w_stat_wr & data_in[STAT_RX_OVF]));

         r_rd_valid <= w_rd;
         if (w_rd) r_data_out <= w_rdata;

         r_irq <= r_ctrl.irq_en & (!w_rx_empty | r_tx_ovf | r_rx_udf | r_rx_ovf);
      end
   end

   assign data_out     = r_data_out;
   assign rd_valid_out = r_rd_valid;
   assign irq_out      = r_irq;

endmodule

// File: tb/tb_mmio_fifo_bridge.sv
// Testbench for mmio_fifo_bridge: register-access vector table, directed multi-cycle
// sequences, and a randomized run checked against a queue-based reference model.
module tb_mmio_fifo_bridge;

   localparam int unsigned DATA_W  = 32;
   localparam int unsigned DEPTH   = 8;
   localparam int unsigned SEL_BIT = 15;
   localparam logic [31:0] BASE    = 32'h0000_8000;

   localparam logic [3:0] O_CTRL = 4'h0;
   localparam logic [3:0] O_TX   = 4'h4;
   localparam logic [3:0] O_RX   = 4'h8;
   localparam logic [3:0] O_STAT = 4'hC;

   localparam int K_IDLE = 0;
   localparam int K_WR   = 1;
   localparam int K_RD   = 2;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic [31:0]       addr_in = '0;
   logic [DATA_W-1:0] data_in = '0;
   logic              wr_in = 1'b0;
   logic              rd_in = 1'b0;
   logic [DATA_W-1:0] data_out;
   logic              rd_valid_out;
   logic              tx_valid_out;
   logic [DATA_W-1:0] tx_data_out;
   logic              tx_ready_in = 1'b0;
   logic              rx_valid_in = 1'b0;
   logic [DATA_W-1:0] rx_data_in = '0;
   logic              rx_ready_out;
   logic              irq_out;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   mmio_fifo_bridge #(
      .DATA_W  (DATA_W),
      .DEPTH   (DEPTH),
      .SEL_BIT (SEL_BIT)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .addr_in      (addr_in),
      .data_in      (data_in),
      .wr_in        (wr_in),
      .rd_in        (rd_in),
      .data_out     (data_out),
      .rd_valid_out (rd_valid_out),
      .tx_valid_out (tx_valid_out),
      .tx_data_out  (tx_data_out),
      .tx_ready_in  (tx_ready_in),
      .rx_valid_in  (rx_valid_in),
      .rx_data_in   (rx_data_in),
      .rx_ready_out (rx_ready_out),
      .irq_out      (irq_out)
   );

   typedef struct {
      int          kind;
      bit          sel;
      logic [3:0]  off;
      logic [31:0] wdata;
      logic [31:0] exp_data;
      bit          exp_valid;
   } vec_t;

   // Reference model state
   logic [31:0] txq[$];
   logic [31:0] rxq[$];
   bit m_en, m_irq_en, m_tovf, m_rudf, m_rovf;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic mmio(input bit wr, input bit rd, input bit sel, input logic [3:0] off,
                       input logic [31:0] wdata);
      addr_in = (sel ? BASE : 32'h0) | {28'h0, off};
      wr_in   = wr;
      rd_in   = rd;
      data_in = wdata;
      tick();
      wr_in   = 1'b0;
      rd_in   = 1'b0;
   endtask

   task automatic mmio_read(input string name, input logic [3:0] off, input logic [31:0] exp);
      mmio(1'b0, 1'b1, 1'b1, off, 32'h0);
      check({name, ".valid"}, {31'h0, rd_valid_out}, 32'h1);
      check(name, data_out, exp);
   endtask

   task automatic do_reset();
      rst         = 1'b0;
      wr_in       = 1'b0;
      rd_in       = 1'b0;
      tx_ready_in = 1'b0;
      rx_valid_in = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      tick();
   endtask

   function automatic logic [31:0] model_status();
      logic [31:0] s;
      s = '0;
      s[0] = (txq.size() == DEPTH);
      s[1] = (txq.size() == 0);
      s[2] = (rxq.size() == DEPTH);
      s[3] = (rxq.size() == 0);
      s[4] = m_tovf;
      s[5] = m_rudf;
      s[6] = m_rovf;
      s[15:8]  = 8'(txq.size());
      s[23:16] = 8'(rxq.size());
      return s;
   endfunction

   initial begin
      vec_t vecs[$];
      logic [31:0] rd_val;

      // ---------------- Register table (streams disabled) ----------------
      vecs.push_back('{K_RD,   1, O_STAT, 32'h0,  32'h0000_000A, 1});
      vecs.push_back('{K_WR,   1, O_CTRL, 32'h8,  32'h0, 0});
      vecs.push_back('{K_RD,   1, O_CTRL, 32'h0,  32'h8, 1});
      vecs.push_back('{K_WR,   1, O_TX,   32'h11, 32'h0, 0});
      vecs.push_back('{K_WR,   1, O_TX,   32'h22, 32'h0, 0});
      vecs.push_back('{K_RD,   1, O_STAT, 32'h0,  32'h0000_0208, 1});
      vecs.push_back('{K_RD,   1, O_TX,   32'h0,  32'h0, 1});
      vecs.push_back('{K_RD,   1, 4'h1,   32'h0,  32'h0, 1});
      vecs.push_back('{K_RD,   1, O_RX,   32'h0,  32'h0, 1});
      vecs.push_back('{K_RD,   1, O_STAT, 32'h0,  32'h0000_0228, 1});
      vecs.push_back('{K_WR,   1, O_STAT, 32'h20, 32'h0, 0});
      vecs.push_back('{K_RD,   1, O_STAT, 32'h0,  32'h0000_0208, 1});
      vecs.push_back('{K_WR,   0, O_TX,   32'h99, 32'h0, 0});
      vecs.push_back('{K_RD,   0, O_STAT, 32'h0,  32'h0, 0});
      vecs.push_back('{K_RD,   1, O_STAT, 32'h0,  32'h0000_0208, 1});
      vecs.push_back('{K_WR,   0, O_CTRL, 32'h1,  32'h0, 0});
      vecs.push_back('{K_RD,   1, O_CTRL, 32'h0,  32'h8, 1});
      vecs.push_back('{K_WR,   1, O_CTRL, 32'h2,  32'h0, 0});
      vecs.push_back('{K_IDLE, 1, O_CTRL, 32'h0,  32'h0, 0});
      vecs.push_back('{K_RD,   1, O_STAT, 32'h0,  32'h0000_000A, 1});
      vecs.push_back('{K_RD,   1, O_CTRL, 32'h0,  32'h0, 1});

      do_reset();
      check("reset.tx_valid", {31'h0, tx_valid_out}, 32'h0);
      check("reset.rx_ready", {31'h0, rx_ready_out}, 32'h0);
      check("reset.irq", {31'h0, irq_out}, 32'h0);
      foreach (vecs[i]) begin
         mmio(vecs[i].kind == K_WR, vecs[i].kind == K_RD, vecs[i].sel, vecs[i].off,
              vecs[i].wdata);
         check($sformatf("vec%0d.valid", i), {31'h0, rd_valid_out}, {31'h0, vecs[i].exp_valid});
         if (vecs[i].exp_valid) check($sformatf("vec%0d.data", i), data_out, vecs[i].exp_data);
      end

      // ---------------- TX stream ordering ----------------
      do_reset();
      mmio(1, 0, 1, O_CTRL, 32'h1);
      mmio(1, 0, 1, O_TX, 32'h11);
      mmio(1, 0, 1, O_TX, 32'h22);
      mmio(1, 0, 1, O_TX, 32'h33);
      mmio_read("tx3.status", O_STAT, 32'h0000_0308);
      tx_ready_in = 1'b1;
      for (int i = 0; i < 3; i++) begin
         check($sformatf("tx3.valid%0d", i), {31'h0, tx_valid_out}, 32'h1);
         check($sformatf("tx3.data%0d", i), tx_data_out, 32'h11 * (i + 1));
         tick();
      end
      check("tx3.drained", {31'h0, tx_valid_out}, 32'h0);
      tx_ready_in = 1'b0;
      mmio_read("tx3.status_empty", O_STAT, 32'h0000_000A);

      // ---------------- TX overflow ----------------
      do_reset();
      mmio(1, 0, 1, O_CTRL, 32'h1);
      for (int i = 0; i < 9; i++) mmio(1, 0, 1, O_TX, 32'h100 + i);
      mmio_read("txovf.status", O_STAT, 32'h0000_0819);
      mmio(1, 0, 1, O_STAT, 32'h10);
      mmio_read("txovf.cleared", O_STAT, 32'h0000_0809);
      tx_ready_in = 1'b1;
      for (int i = 0; i < 8; i++) begin
         check($sformatf("txovf.data%0d", i), tx_data_out, 32'h100 + i);
         tick();
      end
      check("txovf.ninth_dropped", {31'h0, tx_valid_out}, 32'h0);
      tx_ready_in = 1'b0;

      // ---------------- RX + interrupt ----------------
      do_reset();
      mmio(1, 0, 1, O_CTRL, 32'h9);
      rx_valid_in = 1'b1;
      rx_data_in  = 32'hA5;
      tick();
      rx_valid_in = 1'b0;
      check("irq.latency", {31'h0, irq_out}, 32'h0);
      tick();
      check("irq.set", {31'h0, irq_out}, 32'h1);
      mmio_read("rx.pop", O_RX, 32'hA5);
      tick();
      check("rx.pulse", {31'h0, rd_valid_out}, 32'h0);
      check("rx.hold", data_out, 32'hA5);
      check("irq.clear", {31'h0, irq_out}, 32'h0);

      // ---------------- RX underflow / overflow, simultaneous wr+rd ----------------
      do_reset();
      mmio(1, 0, 1, O_CTRL, 32'h1);
      mmio_read("udf.data", O_RX, 32'h0);
      mmio_read("udf.status", O_STAT, 32'h0000_002A);
      rx_valid_in = 1'b1;
      for (int i = 0; i < 9; i++) begin
         rx_data_in = 32'h50 + i;
         check($sformatf("rxfill.ready%0d", i), {31'h0, rx_ready_out}, {31'h0, i < 8});
         tick();
      end
      rx_valid_in = 1'b0;
      check("rxfull.ready", {31'h0, rx_ready_out}, 32'h0);
      mmio(1, 1, 1, O_STAT, 32'h60);
      check("wrrd.valid", {31'h0, rd_valid_out}, 32'h1);
      check("wrrd.pre_write", data_out, 32'h0008_0066);
      mmio_read("wrrd.post_write", O_STAT, 32'h0008_0006);
      mmio_read("rxfull.head", O_RX, 32'h50);

      // ---------------- Flush and mid-stream reset ----------------
      do_reset();
      mmio(1, 0, 1, O_CTRL, 32'h9);
      for (int i = 0; i < 4; i++) mmio(1, 0, 1, O_TX, 32'hC0 + i);
      check("flush.before", {31'h0, tx_valid_out}, 32'h1);
      mmio(1, 0, 1, O_CTRL, 32'h3);
      tick();
      check("flush.tx_empty", {31'h0, tx_valid_out}, 32'h0);
      mmio_read("flush.status", O_STAT, 32'h0000_000A);
      mmio_read("flush.ctrl", O_CTRL, 32'h1);
      mmio(1, 0, 1, O_CTRL, 32'h9);
      mmio(1, 0, 1, O_TX, 32'hD0);
      rx_valid_in = 1'b1;
      rx_data_in  = 32'h77;
      tx_ready_in = 1'b1;
      mmio(0, 1, 1, O_STAT, 32'h0);
      tick();
      #2;
      rst = 1'b0;
      #1;
      check("rst.tx_valid", {31'h0, tx_valid_out}, 32'h0);
      check("rst.rx_ready", {31'h0, rx_ready_out}, 32'h0);
      check("rst.irq", {31'h0, irq_out}, 32'h0);
      check("rst.rd_valid", {31'h0, rd_valid_out}, 32'h0);
      check("rst.data_out", data_out, 32'h0);
      rx_valid_in = 1'b0;
      tx_ready_in = 1'b0;
      do_reset();
      mmio_read("rst.status", O_STAT, 32'h0000_000A);

      // ---------------- Randomized run against the queue model ----------------
      do_reset();
      mmio(1, 0, 1, O_CTRL, 32'h9);
      txq.delete();
      rxq.delete();
      m_en = 1; m_irq_en = 1; m_tovf = 0; m_rudf = 0; m_rovf = 0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         int op;
         bit is_rd, exp_txv, exp_rxr, exp_irq, tx_pop, rx_full_pre, new_en;
         logic [31:0] exp_rd, wd;
         logic [3:0] off;
         op          = $urandom_range(0, 9);
         tx_ready_in = ($urandom_range(0, 2) == 0);
         rx_valid_in = ($urandom_range(0, 2) != 0);
         rx_data_in  = $urandom;
         wd          = $urandom;
         is_rd       = 0;
         new_en      = m_en;
         off         = O_CTRL;
         case (op)
            0, 1, 2: off = O_TX;
            3, 4:    begin off = O_RX; is_rd = 1; end
            5:       begin off = O_STAT; is_rd = 1; end
            6:       begin off = O_STAT; wd = wd & 32'h70; end
            7:       begin new_en = ($urandom_range(0, 3) != 0); wd = {28'h0, 3'b100, new_en}; end
            default: off = O_CTRL;
         endcase
         addr_in = BASE | {28'h0, off};
         data_in = wd;
         wr_in   = (op <= 2) || (op == 6) || (op == 7);
         rd_in   = is_rd;

         exp_txv = m_en && (txq.size() > 0);
         exp_rxr = m_en && (rxq.size() < DEPTH);
         check($sformatf("rnd%0d.tx_valid", cyc), {31'h0, tx_valid_out}, {31'h0, exp_txv});
         if (exp_txv) check($sformatf("rnd%0d.tx_data", cyc), tx_data_out, txq[0]);
         check($sformatf("rnd%0d.rx_ready", cyc), {31'h0, rx_ready_out}, {31'h0, exp_rxr});

         exp_irq = m_irq_en && ((rxq.size() > 0) || m_tovf || m_rudf || m_rovf);
         exp_rd  = 32'h0;
         if (op == 5) exp_rd = model_status();
         if ((op == 3 || op == 4) && rxq.size() > 0) exp_rd = rxq[0];

         // Model update from pre-edge state: clears first so sets win
         if (op == 6) begin
            if (wd[4]) m_tovf = 0;
            if (wd[5]) m_rudf = 0;
            if (wd[6]) m_rovf = 0;
         end
         tx_pop      = exp_txv && tx_ready_in;
         rx_full_pre = (rxq.size() == DEPTH);
         if (tx_pop) void'(txq.pop_front());
         if (op <= 2) begin
            if (txq.size() < DEPTH) txq.push_back(wd);
            else m_tovf = 1;
         end
         if (op == 3 || op == 4) begin
            if (rxq.size() == 0) m_rudf = 1;
            else void'(rxq.pop_front());
         end
         if (rx_valid_in && exp_rxr) rxq.push_back(rx_data_in);
         if (rx_valid_in && m_en && rx_full_pre) m_rovf = 1;

         tick();
         wr_in = 1'b0;
         rd_in = 1'b0;
         m_en  = new_en;
         check($sformatf("rnd%0d.rd_valid", cyc), {31'h0, rd_valid_out}, {31'h0, is_rd});
         if (is_rd) check($sformatf("rnd%0d.rd_data", cyc), data_out, exp_rd);
         check($sformatf("rnd%0d.irq", cyc), {31'h0, irq_out}, {31'h0, exp_irq});
      end
      rx_valid_in = 1'b0;
      tx_ready_in = 1'b0;
      mmio_read("rnd.final_status", O_STAT, model_status());
      rd_val = data_out;

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/mmio_fifo_bridge.md
MMIO_FIFO_BRIDGE -- requirements
Module: mmio_fifo_bridge

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameter DATA_W, default 32: register and stream data width; legal values are 32 or more.
REQ-003 Parameter DEPTH, default 8: entries per FIFO; a power of two from 2 to 128.
REQ-004 Parameter SEL_BIT, default 15: the address bit that selects this block.
REQ-005 Ports SHALL be (name, direction, width, meaning):
  clk  in  1  clock
  rst  in  1  asynchronous active-low reset
  addr_in  in  32  byte address
  data_in  in  DATA_W  write data
  wr_in  in  1  write strobe
  rd_in  in  1  read strobe
  data_out  out  DATA_W  read data
  rd_valid_out  out  1  read-data-valid pulse
  tx_valid_out  out  1  TX stream valid
  tx_data_out  out  DATA_W  TX stream data
  tx_ready_in  in  1  TX stream ready
  rx_valid_in  in  1  RX stream valid
  rx_data_in  in  DATA_W  RX stream data
  rx_ready_out  out  1  RX stream ready
  irq_out  out  1  level interrupt

Function
REQ-006 The block is selected when addr_in[SEL_BIT]=1; the register offset is addr_in[3:0]; wr_in and rd_in without selection SHALL be ignored.
REQ-007 Offset 0x0 CTRL (read/write): bit0 enable, bit1 tx_flush, bit2 rx_flush, bit3 irq_en; flush bits self-clear one cycle after the write.
REQ-008 Offset 0x4 TX_DATA (write-only): a write pushes data_in into the TX FIFO; a read returns 0.
REQ-009 Offset 0x8 RX_DATA (read-only): a read pops the RX FIFO head into data_out; writes are ignored.
REQ-010 Offset 0xC STATUS fields: [0] tx_full, [1] tx_empty, [2] rx_full, [3] rx_empty, [4] tx_ovf, [5] rx_udf, [6] rx_ovf, [15:8] tx_count, [23:16] rx_count; all other bits read 0.
REQ-011 A STATUS write SHALL clear sticky bits [6:4] where data_in has a 1 (write-1-to-clear); if a set and a clear occur in the same cycle, the set wins.
REQ-012 Read latency SHALL be 1 cycle: data_out and rd_valid_out update on the clock edge after a selected rd_in.
- rd_valid_out is a single-cycle pulse.
- data_out holds its value until the next selected read.
- Unmapped offsets return 0 with rd_valid_out=1.
REQ-013 A TX_DATA write when the TX FIFO is full SHALL be dropped and set tx_ovf, unless a TX pop occurs in the same cycle; in that case the write is accepted and the count is unchanged.
REQ-014 An RX_DATA read when the RX FIFO is empty SHALL return 0 and set rx_udf; there is no bypass from rx_data_in.
REQ-015 tx_valid_out = enable AND NOT tx_empty; tx_data_out = TX FIFO head; a pop occurs when tx_valid_out and tx_ready_in are both high.
REQ-016 rx_ready_out = enable AND NOT rx_full; a push occurs when rx_valid_in and rx_ready_out are both high.
- rx_valid_in high while enable=1 and the RX FIFO is full sets rx_ovf.
REQ-017 When enable=0 both stream interfaces SHALL stall; MMIO pushes and pops remain functional.
REQ-018 A flush SHALL empty its FIFO in one cycle and has priority over any push or pop in the same cycle; a flush does not clear sticky bits.
REQ-019 A simultaneous wr_in and rd_in SHALL both be processed; the read returns pre-write register state.
REQ-020 irq_out = irq_en AND (NOT rx_empty OR tx_ovf OR rx_udf OR rx_ovf), registered with 1-cycle latency.
REQ-021 FIFO pointers SHALL wrap modulo DEPTH; counts are log2(DEPTH)+1 bits wide, zero-extended into their STATUS fields.

Reset
REQ-022 Asserting rst SHALL asynchronously clear the following: CTRL, sticky bits, FIFO pointers and counts, data_out, rd_valid_out and irq_out.
- While in reset, tx_valid_out=0, rx_ready_out=0, and STATUS reads 0x0000_000A after release.
REQ-023 Reset deassertion mid-transaction SHALL leave no partial push or pop; FIFO storage contents need no reset.

Structure
REQ-024 Package mmio_pkg SHALL hold the following:
- register offsets (CTRL, TX_DATA, RX_DATA, STATUS);
- CTRL and STATUS bit-index constants;
- the STATUS field positions.
REQ-025 One sub-module, mmio_sync_fifo (parameters DATA_W and DEPTH, with push, pop, flush, full, empty and count), SHALL be instantiated twice, for TX and for RX.

Verification
REQ-026 Setup: reset, then enable=1 with tx_ready_in=0. Write TX_DATA 0x11, 0x22, 0x33 -> STATUS[15:8]=3; raise tx_ready_in -> tx_data_out presents 0x11, 0x22, 0x33 on consecutive cycles, then tx_empty=1.
REQ-027 Fill TX (DEPTH=8) with 9 writes while tx_ready_in=0 -> tx_count=8, tx_ovf=1; write STATUS 0x10 -> tx_ovf=0.
REQ-028 Drive rx_valid_in with 0xA5 and irq_en=1 -> irq_out=1; read RX_DATA -> data_out=0xA5 with rd_valid_out a one-cycle pulse, then irq_out=0.
REQ-029 Read RX_DATA while empty -> data_out=0 and rx_udf=1; hold rx_valid_in with RX full -> rx_ready_out=0 and rx_ovf=1.
REQ-030 With TX holding 4 entries, write CTRL 0x3 -> TX empty next cycle and CTRL reads back 0x1; assert rst mid-stream -> all outputs 0 immediately.
